// File: rtl/bep_pkg.sv
// Shared definitions for the BEP frame assembler: default sizes, FSM state
// encoding and the counter-width helper.
package bep_pkg;

   localparam int BEP_WORD_WIDTH_DEF = 8;
   localparam int BEP_TIMEOUT_DEF    = 64;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } bep_state_t;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int bep_cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/bep_idle_timer.sv
// Saturating idle counter. 'expired' flags the cycle whose update makes the
// count reach TIMEOUT_CYCLES-1 without a clear.
module bep_idle_timer
   import bep_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = BEP_TIMEOUT_DEF
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   localparam int CW = bep_cnt_w(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT_CYCLES - 2);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CNT_LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   assign expired = enable && !clear && (count_q == CNT_PRE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/bep_frame_assembler.sv
// Packs decided-bit strobes MSB-first into words, holds one word for the
// consumer, and closes frames after a period of bit-stream silence.
module bep_frame_assembler
   import bep_pkg::*;
#(
   parameter int WORD_WIDTH     = BEP_WORD_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = BEP_TIMEOUT_DEF
) (
   input  logic                                  clock,
   input  logic                                  reset_n,
   input  logic                                  bit_valid,
   input  logic                                  bit_value,
   output logic [WORD_WIDTH-1:0]                 word_data,
   output logic                                  word_valid,
   input  logic                                  word_ready,
   output logic                                  frame_end,
   output logic                                  frame_error,
   output logic [bep_cnt_w(WORD_WIDTH+1)-1:0]    partial_bits,
   output logic                                  overrun,
   input  logic                                  clear_overrun,
   output logic                                  busy
);

   localparam int BW = bep_cnt_w(WORD_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WORD_WIDTH - 1);

   bep_state_t            state_q, state_d;
   logic [WORD_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [WORD_WIDTH-1:0] word_data_q, word_data_d;
   logic                  word_valid_q, word_valid_d;
   logic                  frame_end_q, frame_end_d;
   logic                  frame_error_q, frame_error_d;
   logic [BW-1:0]         partial_bits_q, partial_bits_d;
   logic                  overrun_q, overrun_d;

   logic [WORD_WIDTH-1:0] shift_next;
   logic                  transfer;
   logic                  complete;
   logic                  drop;
   logic                  timer_enable;
   logic                  timer_expired;

   assign shift_next   = {shift_q[WORD_WIDTH-2:0], bit_value};
   // Handshake: a word moves when word_valid & word_ready are both high at a
   // rising edge; word_valid never drops and word_data never changes before it.
   assign transfer     = word_valid_q && word_ready;
   assign timer_enable = (state_q == COLLECT);

   bep_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (timer_enable),
      .clear   (bit_valid),
      .expired (timer_expired)
   );

   always_comb begin
      state_d        = state_q;
      shift_d        = shift_q;
      bit_cnt_d      = bit_cnt_q;
      word_data_d    = word_data_q;
      word_valid_d   = word_valid_q;
      frame_end_d    = 1'b0;
      frame_error_d  = 1'b0;
      partial_bits_d = '0;
      overrun_d      = overrun_q;
      complete       = 1'b0;
      drop           = 1'b0;

      if (transfer) begin
         word_valid_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (bit_valid) begin
               shift_d   = shift_next;
               bit_cnt_d = BW'(1);
               state_d   = COLLECT;
            end
         end
         COLLECT: begin
            if (bit_valid) begin
               shift_d = shift_next;
               if (bit_cnt_q == LAST_BIT) begin
                  complete  = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (timer_expired) begin
               // Stray bits of an unfinished word are reported and thrown away.
               state_d   = IDLE;
               bit_cnt_d = '0;
               shift_d   = '0;
               if (bit_cnt_q == '0) begin
                  frame_end_d = 1'b1;
               end else begin
                  frame_error_d  = 1'b1;
                  partial_bits_d = bit_cnt_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (complete) begin
         if (!word_valid_q || transfer) begin
            word_data_d  = shift_next;
            word_valid_d = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end

      if (drop) begin
         overrun_d = 1'b1;
      end else if (clear_overrun) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         shift_q        <= '0;
         bit_cnt_q      <= '0;
         word_data_q    <= '0;
         word_valid_q   <= 1'b0;
         frame_end_q    <= 1'b0;
         frame_error_q  <= 1'b0;
         partial_bits_q <= '0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_q        <= shift_d;
         bit_cnt_q      <= bit_cnt_d;
         word_data_q    <= word_data_d;
         word_valid_q   <= word_valid_d;
         frame_end_q    <= frame_end_d;
         frame_error_q  <= frame_error_d;
         partial_bits_q <= partial_bits_d;
         overrun_q      <= overrun_d;
      end
   end

   assign word_data    = word_data_q;
   assign word_valid   = word_valid_q;
   assign frame_end    = frame_end_q;
   assign frame_error  = frame_error_q;
   assign partial_bits = partial_bits_q;
   assign overrun      = overrun_q;
   assign busy         = (state_q == COLLECT);

endmodule

// File: tb/tb_bep_frame_assembler.sv
// Directed bench for bep_frame_assembler: a frame table plus hand-written
// stall, same-cycle, near-timeout and reset sequences.
module tb_bep_frame_assembler;

   localparam int W = 8;
   localparam int T = 64;

   logic         clock         = 1'b0;
   logic         reset_n       = 1'b0;
   logic         bit_valid     = 1'b0;
   logic         bit_value     = 1'b0;
   logic         word_ready    = 1'b0;
   logic         clear_overrun = 1'b0;
   logic [W-1:0] word_data;
   logic         word_valid;
   logic         frame_end;
   logic         frame_error;
   logic [3:0]   partial_bits;
   logic         overrun;
   logic         busy;

   int           n_checks = 0;
   int           n_fail   = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      int          nbits;
      logic [15:0] bits;
      int          nwords;
      logic [7:0]  w0;
      logic [7:0]  w1;
      logic        exp_end;
      logic [3:0]  partial;
   } vec_t;

   vec_t vecs[6];

   bep_frame_assembler #(
      .WORD_WIDTH     (W),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .bit_valid     (bit_valid),
      .bit_value     (bit_value),
      .word_data     (word_data),
      .word_valid    (word_valid),
      .word_ready    (word_ready),
      .frame_end     (frame_end),
      .frame_error   (frame_error),
      .partial_bits  (partial_bits),
      .overrun       (overrun),
      .clear_overrun (clear_overrun),
      .busy          (busy)
   );

   // clock / reset
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard: every accepted word must match the head of exp_q
   always @(negedge clock) begin
      if (reset_n && word_valid === 1'b1 && word_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got word 0x%0h expected none", word_data);
         end else begin
            chk("sb_word", {24'h0, word_data}, {24'h0, exp_q.pop_front()});
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic v);
      bit_valid = 1'b1;
      bit_value = v;
      step();
      bit_valid = 1'b0;
      bit_value = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         send_bit(bits[n-1-i]);
      end
   endtask

   // c0 = cycles elapsed since the last bit strobe (1 right after send_bit)
   task automatic wait_pulse(input string tag, input logic exp_end,
                             input logic [3:0] exp_partial, input int c0);
      int c = c0;
      bit found = 1'b0;
      while (!found && c <= 100) begin
         if (frame_end || frame_error) begin
            found = 1'b1;
         end else begin
            if (c == T - 1) chk({tag, "_busy_before"}, {31'h0, busy}, 32'd1);
            step();
            c++;
         end
      end
      if (!found) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got no frame pulse expected one at cycle %0d", tag, T);
      end else begin
         chk({tag, "_pulse_cycle"}, c, T);
         chk({tag, "_frame_end"}, {31'h0, frame_end}, {31'h0, exp_end});
         chk({tag, "_frame_error"}, {31'h0, frame_error}, {31'h0, !exp_end});
         chk({tag, "_partial"}, {28'h0, partial_bits}, exp_end ? 32'd0 : {28'h0, exp_partial});
         chk({tag, "_busy_fall"}, {31'h0, busy}, 32'd0);
         step();
         chk({tag, "_pulse_width"}, {31'h0, frame_end | frame_error}, 32'd0);
         chk({tag, "_partial_clr"}, {28'h0, partial_bits}, 32'd0);
      end
   endtask

   initial begin
      vecs[0] = '{8,  16'h00A5, 1, 8'hA5, 8'h00, 1'b1, 4'd0};
      vecs[1] = '{11, 16'h02D5, 1, 8'h5A, 8'h00, 1'b0, 4'd3};
      vecs[2] = '{16, 16'h0FF0, 2, 8'h0F, 8'hF0, 1'b1, 4'd0};
      vecs[3] = '{7,  16'h007F, 0, 8'h00, 8'h00, 1'b0, 4'd7};
      vecs[4] = '{1,  16'h0001, 0, 8'h00, 8'h00, 1'b0, 4'd1};
      vecs[5] = '{9,  16'h0187, 1, 8'hC3, 8'h00, 1'b0, 4'd1};

      // reset state
      step();
      step();
      chk("rst_word_valid", {31'h0, word_valid}, 32'd0);
      chk("rst_word_data", {24'h0, word_data}, 32'd0);
      chk("rst_frame_end", {31'h0, frame_end}, 32'd0);
      chk("rst_frame_error", {31'h0, frame_error}, 32'd0);
      chk("rst_partial", {28'h0, partial_bits}, 32'd0);
      chk("rst_overrun", {31'h0, overrun}, 32'd0);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      reset_n = 1'b1;
      step();

      // frame table
      for (int v = 0; v < 6; v++) begin
         word_ready = 1'b1;
         if (vecs[v].nwords > 0) exp_q.push_back(vecs[v].w0);
         if (vecs[v].nwords > 1) exp_q.push_back(vecs[v].w1);
         for (int i = 0; i < vecs[v].nbits; i++) begin
            send_bit(vecs[v].bits[vecs[v].nbits-1-i]);
            if (i == 0) chk("tbl_busy_rise", {31'h0, busy}, 32'd1);
            if (i == 6) chk("tbl_valid_early", {31'h0, word_valid}, 32'd0);
            if (i == 7) begin
               chk("tbl_valid_w0", {31'h0, word_valid}, 32'd1);
               chk("tbl_data_w0", {24'h0, word_data}, {24'h0, vecs[v].w0});
            end
            if (i == 15) begin
               chk("tbl_valid_w1", {31'h0, word_valid}, 32'd1);
               chk("tbl_data_w1", {24'h0, word_data}, {24'h0, vecs[v].w1});
            end
         end
         wait_pulse("tbl", vecs[v].exp_end, vecs[v].partial, 1);
         chk("tbl_sb_empty", exp_q.size(), 32'd0);
      end

      // stall: second word dropped, first held
      word_ready = 1'b0;
      exp_q.push_back(8'h3C);
      send_bits(16'h003C, 8);
      chk("ovr_valid", {31'h0, word_valid}, 32'd1);
      chk("ovr_data_first", {24'h0, word_data}, 32'h3C);
      chk("ovr_not_yet", {31'h0, overrun}, 32'd0);
      send_bits(16'h00FF, 8);
      chk("ovr_data_held", {24'h0, word_data}, 32'h3C);
      chk("ovr_set", {31'h0, overrun}, 32'd1);
      clear_overrun = 1'b1;
      step();
      clear_overrun = 1'b0;
      chk("ovr_cleared", {31'h0, overrun}, 32'd0);
      chk("ovr_still_valid", {31'h0, word_valid}, 32'd1);
      word_ready = 1'b1;
      step();
      chk("ovr_drained", {31'h0, word_valid}, 32'd0);
      wait_pulse("ovr", 1'b1, 4'd0, 3);

      // completion on the same cycle as the transfer of the held word
      word_ready = 1'b0;
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      send_bits(16'h00AA, 8);
      chk("same_first", {24'h0, word_data}, 32'hAA);
      send_bits(16'h002A, 7);
      word_ready = 1'b1;
      send_bit(1'b1);
      chk("same_valid", {31'h0, word_valid}, 32'd1);
      chk("same_data", {24'h0, word_data}, 32'h55);
      chk("same_no_ovr", {31'h0, overrun}, 32'd0);
      step();
      chk("same_drained", {31'h0, word_valid}, 32'd0);
      wait_pulse("same", 1'b1, 4'd0, 2);

      // a bit on the would-be timeout cycle keeps the frame alive
      begin
         logic seen = 1'b0;
         word_ready = 1'b1;
         exp_q.push_back(8'h96);
         send_bits(16'h0009, 4);
         for (int k = 0; k < T - 2; k++) begin
            step();
            seen = seen | frame_end | frame_error;
         end
         send_bit(1'b0);
         seen = seen | frame_end | frame_error;
         chk("late_no_pulse", {31'h0, seen}, 32'd0);
         chk("late_busy", {31'h0, busy}, 32'd1);
         send_bits(16'h0006, 3);
         chk("late_valid", {31'h0, word_valid}, 32'd1);
         chk("late_data", {24'h0, word_data}, 32'h96);
         wait_pulse("late", 1'b1, 4'd0, 1);
      end

      // asynchronous reset mid-stall and mid-word
      word_ready = 1'b0;
      send_bits(16'h8181, 16);
      send_bits(16'h0005, 3);
      chk("prerst_overrun", {31'h0, overrun}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_word_valid", {31'h0, word_valid}, 32'd0);
      chk("arst_word_data", {24'h0, word_data}, 32'd0);
      chk("arst_overrun", {31'h0, overrun}, 32'd0);
      chk("arst_busy", {31'h0, busy}, 32'd0);
      chk("arst_pulses", {31'h0, frame_end | frame_error}, 32'd0);
      exp_q.delete();
      step();
      reset_n = 1'b1;
      step();
      word_ready = 1'b1;
      exp_q.push_back(8'hE7);
      send_bits(16'h00E7, 8);
      chk("post_valid", {31'h0, word_valid}, 32'd1);
      chk("post_data", {24'h0, word_data}, 32'hE7);
      wait_pulse("post", 1'b1, 4'd0, 1);
      chk("final_sb_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bep_frame_assembler.md
# bep_frame_assembler

Downstream consumer of the pulse-width bit classifier in the BEP decode path. It takes the classifier's one-cycle decided-bit strobes, shifts them MSB-first into words, and hands completed words to the next stage over a valid/ready handshake. It detects end-of-frame by bit-stream silence and reports frames that end with a partial word. It also reports words lost because the consumer stalled.

## Interface
- `WORD_WIDTH`, default 8: bits per output word; must be ≥ 2.
- `TIMEOUT_CYCLES`, default 64: idle clock cycles after the last bit that close a frame; must be ≥ 2.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
- `bit_valid`  in  1  one-cycle strobe: a decided bit is present.
- `bit_value`  in  1  decided bit, sampled only when `bit_valid`=1.
- `word_data`  out  WORD_WIDTH  completed word; stable while `word_valid`=1 and `word_ready`=0.
- `word_valid`  out  1  `word_data` holds an unconsumed word.
- `word_ready`  in  1  consumer accepts; transfer when `word_valid` & `word_ready`.
- `frame_end`  out  1  one-cycle pulse: frame closed on a word boundary.
- `frame_error`  out  1  one-cycle pulse: frame closed with 1..WORD_WIDTH-1 stray bits.
- `partial_bits`  out  clog2(WORD_WIDTH+1)  stray-bit count; valid with `frame_error`, else 0.
- `overrun`  out  1  sticky: a completed word was dropped.
- `clear_overrun`  in  1  synchronous clear of `overrun`.
- `busy`  out  1  high while in COLLECT.

## Operation
- States: IDLE, COLLECT.
  - IDLE: `bit_valid` shifts the bit in, bit count = 1, idle counter = 0, go to COLLECT.
  - COLLECT: each `bit_valid` shifts the bit in (`shift <= {shift[W-2:0], bit_value}`) and clears the idle counter. Otherwise the idle counter increments.
  - Timeout in COLLECT: idle counter reaches TIMEOUT_CYCLES-1 with no `bit_valid`. Go to IDLE and clear the bit count.
    - Bit count 0: pulse `frame_end`.
    - Bit count >0: pulse `frame_error`, drive `partial_bits` = count, and discard the stray bits.
- Word completion: the bit that makes the count WORD_WIDTH resets the count to 0 and moves the assembled word into the holding register.
  - Holding register empty, or being consumed this cycle: load the word and set/keep `word_valid`=1.
  - Otherwise: drop the word, keep the old word, and set `overrun`.
- Assembly continues while a word is held; the consumer stall does not block bit intake.
- `overrun` clear: when `clear_overrun` and a drop occur in the same cycle, set wins.
- Idle counter width: clog2(TIMEOUT_CYCLES). It saturates and does not wrap.
- Bit count width: clog2(WORD_WIDTH+1).

## Timing
- Reset values: `word_data`=0, `word_valid`=0, `frame_end`=0, `frame_error`=0, `partial_bits`=0, `overrun`=0, `busy`=0. State is IDLE; shift register, counts and idle counter are 0.
- Word latency: `word_valid` rises the cycle after the final `bit_valid`.
- Timeout pulse: `frame_end` or `frame_error` is asserted TIMEOUT_CYCLES cycles after the last `bit_valid` cycle. It is high for exactly 1 cycle, and `busy` falls in that same cycle.
- `bit_valid` on the would-be timeout cycle: the bit wins; no pulse, and the idle counter restarts.
- `bit_valid` on back-to-back cycles: every cycle is accepted; there is no minimum spacing.
- Handshake: `word_valid` stays high until a transfer. `word_data` must not change while stalled.
- Completion and transfer in the same cycle: the new word is loaded, `word_valid` stays 1, and `overrun` is unchanged.
- `reset_n` low mid-frame: all state clears immediately. A held word is lost and no pulse is emitted.

## Structure
- Shared package `bep_pkg`:
  - default WORD_WIDTH and TIMEOUT_CYCLES constants;
  - state enum {IDLE, COLLECT};
  - width helper for the counters.
- Sub-module `bep_idle_timer`: a saturating idle counter with a `clear` input and a one-cycle `expired` output. The top level owns the FSM, shift register and holding register.

## Test plan
- Bits 1,0,1,0,0,1,0,1 on consecutive cycles with `word_ready`=1 → `word_valid` high 1 cycle after bit 8 with `word_data`=0xA5. `frame_end` pulses 64 cycles after bit 8, and `busy` falls with it.
- 11 bits, then silence → one word with `word_valid`. After 64 cycles, `frame_error`=1 with `partial_bits`=3, and no `frame_end`.
- `word_ready`=0, 16 bits (0x3C then 0xFF) → `word_data` stays 0x3C and `overrun`=1. Then `clear_overrun` clears it and `word_ready` pulse transfers 0x3C.
- 8th bit of a second word arrives on the same cycle as the transfer of the first → `word_valid` stays high, the new word appears next cycle, and `overrun` stays 0.
- `bit_valid` exactly 63 idle cycles after the previous bit → no timeout pulse, and the frame continues.
- `reset_n` pulsed low mid-word and mid-stall → all outputs are 0 immediately. The next 8 bits form a clean word.
